// File: rtl/cp0_sys_ctrl_if.sv
// MTC0/MFC0, exception-commit and redirect signals between the M stage and CP0.
// master = pipeline side, slave = cp0_sys_ctrl.
interface cp0_sys_ctrl_if #(
    parameter int unsigned TLB_ENTRIES = 32,
    parameter int unsigned HW_INT      = 6
);
    localparam int unsigned IDXW = $clog2(TLB_ENTRIES);

    logic              we;
    logic [4:0]        waddr;
    logic [2:0]        wsel;
    logic [31:0]       wdata;
    logic [4:0]        raddr;
    logic [2:0]        rsel;
    logic [31:0]       rdata;
    logic [HW_INT-1:0] int_i;
    logic              exc_valid;
    logic [4:0]        exc_code;
    logic              exc_refill;
    logic [31:0]       exc_pc;
    logic              exc_bd;
    logic [31:0]       exc_badva;
    logic              eret;
    logic              int_req;
    logic [31:0]       exc_vector;
    logic [31:0]       epc_o;
    logic [31:0]       status_o;
    logic [IDXW-1:0]   index_o;
    logic [IDXW-1:0]   random_o;

    modport master (
        output we, waddr, wsel, wdata, raddr, rsel, int_i,
               exc_valid, exc_code, exc_refill, exc_pc, exc_bd, exc_badva, eret,
        input  rdata, int_req, exc_vector, epc_o, status_o, index_o, random_o
    );

    modport slave (
        input  we, waddr, wsel, wdata, raddr, rsel, int_i,
               exc_valid, exc_code, exc_refill, exc_pc, exc_bd, exc_badva, eret,
        output rdata, int_req, exc_vector, epc_o, status_o, index_o, random_o
    );
endinterface

// File: rtl/cp0_sys_ctrl.sv
// CP0 system-control block: privileged registers, prescaled Count/Compare timer,
// Random replacement index, registered interrupt request and exception redirect.
module cp0_sys_ctrl #(
    parameter int unsigned TLB_ENTRIES = 32,
    parameter int unsigned HW_INT      = 6,
    parameter int unsigned COUNT_DIV   = 2,
    parameter logic [31:0] EBASE_RESET = 32'h8000_0000,
    parameter logic [31:0] PRID_VAL    = 32'h0000_4220
) (
    input logic           clk,
    input logic           rst,
    cp0_sys_ctrl_if.slave bus
);
    localparam int unsigned     IDXW        = $clog2(TLB_ENTRIES);
    localparam logic [IDXW-1:0] RAND_MAX    = IDXW'(TLB_ENTRIES - 1);
    localparam logic [31:0]     STATUS_WMSK = 32'h1040_FF17;
    localparam logic [31:0]     ENTRYHI_MSK = 32'hFFFF_E0FF;
    localparam logic [31:0]     EBASE_WMSK  = 32'h3FFF_F000;
    localparam logic [31:0]     STATUS_RST  = 32'h0040_0004;

    logic [31:0]     status_q, status_d, count_q, count_d, compare_q, compare_d;
    logic [31:0]     epc_q, epc_d, badva_q, badva_d, entryhi_q, entryhi_d, ebase_q, ebase_d;
    logic [IDXW-1:0] index_q, index_d, wired_q, wired_d, random_q, random_d;
    logic [1:0]      presc_q, presc_d, ip_sw_q, ip_sw_d;
    logic [5:0]      ip_hw_q, ip_hw_d;
    logic [4:0]      excode_q, excode_d;
    logic            ti_q, ti_d, bd_q, bd_d, iv_q, iv_d, int_req_q, int_req_d;

    logic        tick, match, mtc0;
    logic [31:0] count_inc, cause, base, offset;
    logic [7:0]  ip;
    logic [5:0]  hw_in;

    assign tick      = (presc_q == 2'(COUNT_DIV - 1));
    assign count_inc = count_q + 32'd1;
    assign match     = tick && (count_inc == compare_q);
    // An MTC0 is dropped whenever an exception or ERET commits in the same cycle.
    assign mtc0      = bus.we & ~bus.exc_valid & ~bus.eret;
    // IP7 shares the timer with the sixth hardware line; ip_hw_q[5] is 0 when HW_INT < 6.
    assign ip        = {ti_q | ip_hw_q[5], ip_hw_q[4:0], ip_sw_q};
    assign cause     = {bd_q, ti_q, 6'b0, iv_q, 7'b0, ip, 1'b0, excode_q, 2'b0};

    always_comb begin
        hw_in             = '0;
        hw_in[HW_INT-1:0] = bus.int_i;

        presc_d   = tick ? 2'd0 : presc_q + 2'd1;
        count_d   = tick ? count_inc : count_q;
        ti_d      = ti_q | match;
        random_d  = (random_q <= wired_q) ? RAND_MAX : random_q - 1'b1;
        ip_hw_d   = hw_in;
        int_req_d = status_q[0] & ~status_q[1] & ~status_q[2] & |(ip & status_q[15:8]);
        status_d  = status_q;
        compare_d = compare_q;
        epc_d     = epc_q;
        badva_d   = badva_q;
        entryhi_d = entryhi_q;
        ebase_d   = ebase_q;
        index_d   = index_q;
        wired_d   = wired_q;
        ip_sw_d   = ip_sw_q;
        excode_d  = excode_q;
        bd_d      = bd_q;
        iv_d      = iv_q;

        if (bus.exc_valid) begin
            excode_d = bus.exc_code;
            if (!status_q[1]) begin
                epc_d = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
                bd_d  = bus.exc_bd;
            end
            status_d[1] = 1'b1;
            if (bus.exc_code >= 5'd1 && bus.exc_code <= 5'd5) badva_d = bus.exc_badva;
            if (bus.exc_code >= 5'd1 && bus.exc_code <= 5'd3)
                entryhi_d[31:13] = bus.exc_badva[31:13];
        end else if (bus.eret) begin
            if (status_q[2]) status_d[2] = 1'b0;
            else             status_d[1] = 1'b0;
        end else if (mtc0) begin
            case ({bus.waddr, bus.wsel})
                {5'd0, 3'd0}:  index_d = bus.wdata[IDXW-1:0];
                {5'd6, 3'd0}: begin
                    wired_d  = bus.wdata[IDXW-1:0];
                    random_d = RAND_MAX;
                end
                {5'd9, 3'd0}: begin
                    count_d = bus.wdata;
                    presc_d = 2'd0;
                    if (match) ti_d = 1'b0;
                end
                {5'd10, 3'd0}: entryhi_d = bus.wdata & ENTRYHI_MSK;
                {5'd11, 3'd0}: begin
                    compare_d = bus.wdata;
                    ti_d      = 1'b0;
                end
                {5'd12, 3'd0}: status_d = (status_q & ~STATUS_WMSK) | (bus.wdata & STATUS_WMSK);
                {5'd13, 3'd0}: begin
                    iv_d    = bus.wdata[23];
                    ip_sw_d = bus.wdata[9:8];
                end
                {5'd14, 3'd0}: epc_d = bus.wdata;
                {5'd15, 3'd1}: ebase_d = (ebase_q & ~EBASE_WMSK) | (bus.wdata & EBASE_WMSK);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= STATUS_RST;
            count_q   <= '0;
            compare_q <= '0;
            epc_q     <= '0;
            badva_q   <= '0;
            entryhi_q <= '0;
            ebase_q   <= EBASE_RESET;
            index_q   <= '0;
            wired_q   <= '0;
            random_q  <= RAND_MAX;
            presc_q   <= '0;
            ip_sw_q   <= '0;
            ip_hw_q   <= '0;
            excode_q  <= '0;
            ti_q      <= 1'b0;
            bd_q      <= 1'b0;
            iv_q      <= 1'b0;
            int_req_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            epc_q     <= epc_d;
            badva_q   <= badva_d;
            entryhi_q <= entryhi_d;
            ebase_q   <= ebase_d;
            index_q   <= index_d;
            wired_q   <= wired_d;
            random_q  <= random_d;
            presc_q   <= presc_d;
            ip_sw_q   <= ip_sw_d;
            ip_hw_q   <= ip_hw_d;
            excode_q  <= excode_d;
            ti_q      <= ti_d;
            bd_q      <= bd_d;
            iv_q      <= iv_d;
            int_req_q <= int_req_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case ({bus.raddr, bus.rsel})
            {5'd0, 3'd0}:  bus.rdata = 32'(index_q);
            {5'd1, 3'd0}:  bus.rdata = 32'(random_q);
            {5'd6, 3'd0}:  bus.rdata = 32'(wired_q);
            {5'd8, 3'd0}:  bus.rdata = badva_q;
            {5'd9, 3'd0}:  bus.rdata = count_q;
            {5'd10, 3'd0}: bus.rdata = entryhi_q;
            {5'd11, 3'd0}: bus.rdata = compare_q;
            {5'd12, 3'd0}: bus.rdata = status_q;
            {5'd13, 3'd0}: bus.rdata = cause;
            {5'd14, 3'd0}: bus.rdata = epc_q;
            {5'd15, 3'd0}: bus.rdata = PRID_VAL;
            {5'd15, 3'd1}: bus.rdata = ebase_q;
            default:       bus.rdata = '0;
        endcase
    end

    // Refill uses offset 0 only for a first-level miss; IV routes interrupts to 0x200.
    assign base   = status_q[22] ? 32'hBFC0_0200 : ebase_q;
    assign offset = (bus.exc_refill & ~status_q[1]) ? 32'h0 :
                    (iv_q && bus.exc_code == 5'd0)  ? 32'h200 : 32'h180;

    assign bus.exc_vector = base + offset;
    assign bus.int_req    = int_req_q;
    assign bus.epc_o      = epc_q;
    assign bus.status_o   = status_q;
    assign bus.index_o    = index_q;
    assign bus.random_o   = random_q;
endmodule

// File: tb/tb_cp0_sys_ctrl.sv
// Directed-vector bench for cp0_sys_ctrl with TLB_ENTRIES=32, HW_INT=6, COUNT_DIV=2.
module tb_cp0_sys_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    cp0_sys_ctrl_if #(.TLB_ENTRIES(32), .HW_INT(6)) bus ();

    cp0_sys_ctrl #(
        .TLB_ENTRIES(32),
        .HW_INT     (6),
        .COUNT_DIV  (2),
        .EBASE_RESET(32'h8000_0000),
        .PRID_VAL   (32'h0000_4220)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [2:0] s, input string tag,
                      input logic [31:0] exp);
        bus.raddr = a;
        bus.rsel  = s;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wsel  = s;
        bus.wdata = d;
        tick();
        bus.we = 1'b0;
    endtask

    initial begin
        bus.we = 0; bus.waddr = 0; bus.wsel = 0; bus.wdata = 0;
        bus.raddr = 0; bus.rsel = 0; bus.int_i = 0;
        bus.exc_valid = 0; bus.exc_code = 0; bus.exc_refill = 0;
        bus.exc_pc = 0; bus.exc_bd = 0; bus.exc_badva = 0; bus.eret = 0;

        // Reset values, read while reset is still asserted so Random has not moved.
        tick();
        tick();
        rd(5'd12, 3'd0, "rst_status", 32'h0040_0004);
        rd(5'd15, 3'd0, "rst_prid", 32'h0000_4220);
        rd(5'd15, 3'd1, "rst_ebase", 32'h8000_0000);
        check("rst_random", 32'(bus.random_o), 32'd31);
        check("rst_int_req", 32'(bus.int_req), 32'd0);
        check("rst_vector", bus.exc_vector, 32'hBFC0_0380);
        rst = 1'b0;

        // Timer: Compare=5, Count=0 -> TI after 10 cycles with COUNT_DIV=2.
        wr(5'd11, 3'd0, 32'd5);
        wr(5'd9, 3'd0, 32'd0);
        repeat (9) tick();
        rd(5'd9, 3'd0, "count_9cyc", 32'd4);
        rd(5'd13, 3'd0, "cause_no_ti", 32'h0000_0000);
        tick();
        rd(5'd13, 3'd0, "cause_ti", 32'h4000_8000);
        rd(5'd9, 3'd0, "count_10cyc", 32'd5);

        // IE=1, IM7=1, EXL=ERL=BEV=0: int_req follows one cycle later.
        wr(5'd12, 3'd0, 32'h0000_8001);
        check("int_req_lat", 32'(bus.int_req), 32'd0);
        tick();
        check("int_req_set", 32'(bus.int_req), 32'd1);
        wr(5'd11, 3'd0, 32'h0000_0100);
        rd(5'd13, 3'd0, "cause_ti_clr", 32'h0000_0000);
        check("int_req_hold", 32'(bus.int_req), 32'd1);
        tick();
        check("int_req_clr", 32'(bus.int_req), 32'd0);

        bus.int_i = 6'b000001;
        tick();
        rd(5'd13, 3'd0, "cause_ip2", 32'h0000_0400);
        bus.int_i = 6'b000000;
        tick();

        // First exception in a delay slot.
        bus.exc_valid = 1'b1; bus.exc_code = 5'd4; bus.exc_pc = 32'h8000_1000;
        bus.exc_bd = 1'b1; bus.exc_badva = 32'h0000_1235;
        #1;
        check("vec_general", bus.exc_vector, 32'h8000_0180);
        tick();
        check("exc_epc", bus.epc_o, 32'h8000_0FFC);
        rd(5'd13, 3'd0, "exc_cause", 32'h8000_0010);
        rd(5'd8, 3'd0, "exc_badva", 32'h0000_1235);
        check("exc_status", bus.status_o, 32'h0000_8003);

        // Nested exception: EPC/BD/BadVAddr untouched.
        bus.exc_code = 5'd10; bus.exc_pc = 32'h9000_0000; bus.exc_bd = 1'b0;
        bus.exc_badva = 32'hDEAD_0000;
        tick();
        bus.exc_valid = 1'b0;
        check("nest_epc", bus.epc_o, 32'h8000_0FFC);
        rd(5'd13, 3'd0, "nest_cause", 32'h8000_0028);
        rd(5'd8, 3'd0, "nest_badva", 32'h0000_1235);

        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        check("eret_exl", bus.status_o, 32'h0000_8001);

        // EBase only writes bits 29:12; refill vector uses offset 0 while EXL=0.
        wr(5'd15, 3'd1, 32'hFFFF_F123);
        rd(5'd15, 3'd1, "ebase_wr", 32'hBFFF_F000);
        bus.exc_refill = 1'b1; bus.exc_code = 5'd2;
        #1;
        check("vec_refill", bus.exc_vector, 32'hBFFF_F000);
        bus.exc_valid = 1'b1; bus.exc_pc = 32'h0040_0000; bus.exc_bd = 1'b0;
        bus.exc_badva = 32'h1234_5678;
        tick();
        bus.exc_valid = 1'b0;
        check("refill_epc", bus.epc_o, 32'h0040_0000);
        rd(5'd10, 3'd0, "refill_entryhi", 32'h1234_4000);
        rd(5'd8, 3'd0, "refill_badva", 32'h1234_5678);
        check("vec_refill_exl", bus.exc_vector, 32'hBFFF_F180);
        bus.exc_refill = 1'b0;

        // ERET with ERL=EXL=1 clears only ERL.
        wr(5'd12, 3'd0, 32'h0000_8007);
        bus.eret = 1'b1;
        tick();
        check("eret_erl", bus.status_o, 32'h0000_8003);
        tick();
        bus.eret = 1'b0;
        check("eret_exl2", bus.status_o, 32'h0000_8001);

        // Exception, ERET and MTC0 EPC together: exception wins, write dropped.
        bus.exc_valid = 1'b1; bus.exc_code = 5'd0; bus.exc_pc = 32'h8000_2000;
        bus.eret = 1'b1;
        wr(5'd14, 3'd0, 32'hDEAD_BEEF);
        bus.exc_valid = 1'b0; bus.eret = 1'b0;
        check("prio_epc", bus.epc_o, 32'h8000_2000);
        check("prio_status", bus.status_o, 32'h0000_8003);

        // Cause.IV routes interrupt exceptions to offset 0x200.
        wr(5'd13, 3'd0, 32'h0080_0000);
        rd(5'd13, 3'd0, "cause_iv", 32'h0080_0000);
        check("vec_iv", bus.exc_vector, 32'hBFFF_F200);

        // Wired=28: Random walks 31,30,29,28,31,30.
        wr(5'd6, 3'd0, 32'd28);
        check("rand_0", 32'(bus.random_o), 32'd31);
        tick();
        check("rand_1", 32'(bus.random_o), 32'd30);
        tick();
        check("rand_2", 32'(bus.random_o), 32'd29);
        tick();
        check("rand_3", 32'(bus.random_o), 32'd28);
        tick();
        check("rand_4", 32'(bus.random_o), 32'd31);
        tick();
        check("rand_5", 32'(bus.random_o), 32'd30);

        // Mid-run reset restores everything.
        rst = 1'b1;
        tick();
        check("mrst_status", bus.status_o, 32'h0040_0004);
        check("mrst_epc", bus.epc_o, 32'h0);
        check("mrst_random", 32'(bus.random_o), 32'd31);
        rd(5'd9, 3'd0, "mrst_count", 32'h0);
        rd(5'd6, 3'd0, "mrst_wired", 32'h0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
